// File: rtl/rob_retire_pkg.sv
// Shared reorder-buffer types and default sizing for the rename back end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rob_retire_pkg;

  localparam int TAG_W     = 6;   // 64 physical registers
  localparam int ARCH_W    = 5;   // 32 architectural registers
  localparam int ROB_DEPTH = 16;

  // One reorder-buffer slot. valid/done are control state; the rest is payload
  // captured at allocation and consumed at retire.
  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_rd;
    logic [ARCH_W-1:0] rd;
    logic [TAG_W-1:0]  tag_new;
    logic [TAG_W-1:0]  tag_old;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_ptr.sv
// Circular pointer with an extra wrap bit so full and empty are distinguishable.
// Latency: increment visible the cycle after inc_i.
// Backpressure: none; the caller only asserts inc_i when the move is legal.
module rob_ptr #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             wrap_o
);
  import rob_retire_pkg::*;

  logic [IDX_W:0] ptr_q;
  logic [IDX_W:0] ptr_d;

  // Natural overflow of the IDX_W+1 bit value gives modulo 2*DEPTH counting.
  assign ptr_d = ptr_q + {{IDX_W{1'b0}}, inc_i};

  // Pointer register, cleared to slot 0 with wrap bit 0.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign idx_o  = ptr_q[IDX_W-1:0];
  assign wrap_o = ptr_q[IDX_W];

endmodule

// File: rtl/rob_retire.sv
// In-order reorder buffer: allocates from rename, marks completions, retires in program order.
// Latency: complete edge sets done, next edge retires, retire/free pulses visible the cycle after.
// Backpressure: alloc_ready_o drops when all DEPTH slots are occupied; alloc while full is dropped.
module rob_retire #(
  parameter int DEPTH  = rob_retire_pkg::ROB_DEPTH,
  parameter int TAG_W  = rob_retire_pkg::TAG_W,
  parameter int ARCH_W = rob_retire_pkg::ARCH_W,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid_i,
  input  logic              alloc_has_rd_i,
  input  logic [ARCH_W-1:0] alloc_rd_i,
  input  logic [TAG_W-1:0]  alloc_tag_new_i,
  input  logic [TAG_W-1:0]  alloc_tag_old_i,
  output logic              alloc_ready_o,
  output logic [IDX_W-1:0]  alloc_idx_o,
  input  logic              complete_valid_i,
  input  logic [IDX_W-1:0]  complete_idx_i,
  output logic              retire_valid_o,
  output logic [ARCH_W-1:0] retire_rd_o,
  output logic [TAG_W-1:0]  retire_tag_o,
  output logic              free_valid_o,
  output logic [TAG_W-1:0]  free_tag_o,
  output logic [IDX_W:0]    count_o
);
  import rob_retire_pkg::*;

  rob_entry_t rob_q [DEPTH];

  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             head_wrap, tail_wrap;
  logic             full;
  logic             alloc_fire;
  logic             retire_fire;
  logic             free_fire;
  rob_entry_t       head_ent;
  rob_entry_t       alloc_ent;

  logic              retire_valid_q;
  logic [ARCH_W-1:0] retire_rd_q;
  logic [TAG_W-1:0]  retire_tag_q;
  logic              free_valid_q;
  logic [TAG_W-1:0]  free_tag_q;

  rob_ptr #(.IDX_W(IDX_W)) u_head (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (retire_fire),
    .idx_o  (head_idx),
    .wrap_o (head_wrap)
  );

  rob_ptr #(.IDX_W(IDX_W)) u_tail (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (alloc_fire),
    .idx_o  (tail_idx),
    .wrap_o (tail_wrap)
  );

  // Full when the slot indices meet but the pointers are a lap apart.
  assign full          = (head_idx == tail_idx) && (head_wrap != tail_wrap);
  assign alloc_ready_o = !full;
  assign alloc_idx_o   = tail_idx;
  assign count_o       = {tail_wrap, tail_idx} - {head_wrap, head_idx};
  assign alloc_fire    = alloc_valid_i && !full;

  // Retire looks only at registered state, so a completion landing on the head
  // this cycle is seen one cycle later.
  assign head_ent    = rob_q[head_idx];
  assign retire_fire = head_ent.valid && head_ent.done;
  assign free_fire   = retire_fire && head_ent.has_rd && (head_ent.rd != '0);

  // Assemble the new entry from the rename-side fields.
  always_comb begin
    alloc_ent         = '0;
    alloc_ent.valid   = 1'b1;
    alloc_ent.done    = 1'b0;
    alloc_ent.has_rd  = alloc_has_rd_i;
    alloc_ent.rd      = alloc_rd_i;
    alloc_ent.tag_new = alloc_tag_new_i;
    alloc_ent.tag_old = alloc_tag_old_i;
  end

  // Entry array: completion marks done, retire frees the head, allocate fills the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i].valid <= 1'b0;
        rob_q[i].done  <= 1'b0;
      end
    end else begin
      if (complete_valid_i && rob_q[complete_idx_i].valid) begin
        rob_q[complete_idx_i].done <= 1'b1;
      end
      if (retire_fire) begin
        rob_q[head_idx].valid <= 1'b0;
      end
      // Tail slot cannot equal head slot here: that only happens when full or empty,
      // and full blocks allocation while empty blocks retire.
      if (alloc_fire) begin
        rob_q[tail_idx] <= alloc_ent;
      end
    end
  end

  // Retire and free outputs, one-cycle pulses; payloads hold between retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_valid_q <= 1'b0;
      retire_rd_q    <= '0;
      retire_tag_q   <= '0;
      free_valid_q   <= 1'b0;
      free_tag_q     <= '0;
    end else begin
      retire_valid_q <= retire_fire;
      free_valid_q   <= free_fire;
      if (retire_fire) begin
        retire_rd_q  <= head_ent.rd;
        retire_tag_q <= head_ent.tag_new;
      end
      if (free_fire) begin
        free_tag_q <= head_ent.tag_old;
      end
    end
  end

  assign retire_valid_o = retire_valid_q;
  assign retire_rd_o    = retire_rd_q;
  assign retire_tag_o   = retire_tag_q;
  assign free_valid_o   = free_valid_q;
  assign free_tag_o     = free_tag_q;

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire against a program-order queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rob_retire;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 6;
  localparam int ARCH_W = 5;
  localparam int IDX_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid_i;
  logic              alloc_has_rd_i;
  logic [ARCH_W-1:0] alloc_rd_i;
  logic [TAG_W-1:0]  alloc_tag_new_i;
  logic [TAG_W-1:0]  alloc_tag_old_i;
  logic              alloc_ready_o;
  logic [IDX_W-1:0]  alloc_idx_o;
  logic              complete_valid_i;
  logic [IDX_W-1:0]  complete_idx_i;
  logic              retire_valid_o;
  logic [ARCH_W-1:0] retire_rd_o;
  logic [TAG_W-1:0]  retire_tag_o;
  logic              free_valid_o;
  logic [TAG_W-1:0]  free_tag_o;
  logic [IDX_W:0]    count_o;

  rob_retire dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_valid_i    (alloc_valid_i),
    .alloc_has_rd_i   (alloc_has_rd_i),
    .alloc_rd_i       (alloc_rd_i),
    .alloc_tag_new_i  (alloc_tag_new_i),
    .alloc_tag_old_i  (alloc_tag_old_i),
    .alloc_ready_o    (alloc_ready_o),
    .alloc_idx_o      (alloc_idx_o),
    .complete_valid_i (complete_valid_i),
    .complete_idx_i   (complete_idx_i),
    .retire_valid_o   (retire_valid_o),
    .retire_rd_o      (retire_rd_o),
    .retire_tag_o     (retire_tag_o),
    .free_valid_o     (free_valid_o),
    .free_tag_o       (free_tag_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: slots in program order plus per-slot payload and done flag.
  int order_q[$];
  int m_rd   [DEPTH];
  int m_hr   [DEPTH];
  int m_tn   [DEPTH];
  int m_to   [DEPTH];
  int m_done [DEPTH];
  int alloc_cnt;
  int exp_rv, exp_fv, exp_rrd, exp_rtag, exp_ftag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(input int slot);
    foreach (order_q[i]) if (order_q[i] == slot) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive inputs, check state-derived outputs, advance model, check pulses.
  task automatic step(input bit av, input bit hr, input int rd, input int tn, input int to,
                      input bit cv, input int ci);
    bit ready;
    bit ret;
    int slot;
    alloc_valid_i    = av;
    alloc_has_rd_i   = hr;
    alloc_rd_i       = ARCH_W'(rd);
    alloc_tag_new_i  = TAG_W'(tn);
    alloc_tag_old_i  = TAG_W'(to);
    complete_valid_i = cv;
    complete_idx_i   = IDX_W'(ci);

    ready = (order_q.size() < DEPTH);
    chk("alloc_ready", alloc_ready_o, ready);
    chk("count", count_o, order_q.size());
    chk("alloc_idx", alloc_idx_o, alloc_cnt % DEPTH);

    ret = (order_q.size() > 0) && (m_done[order_q[0]] != 0);
    if (ret) begin
      slot     = order_q.pop_front();
      exp_rv   = 1;
      exp_rrd  = m_rd[slot];
      exp_rtag = m_tn[slot];
      exp_fv   = (m_hr[slot] != 0 && m_rd[slot] != 0) ? 1 : 0;
      if (exp_fv != 0) exp_ftag = m_to[slot];
      m_done[slot] = 0;
    end else begin
      exp_rv = 0;
      exp_fv = 0;
    end
    if (cv && pending(ci)) m_done[ci] = 1;
    if (av && ready) begin
      slot         = alloc_cnt % DEPTH;
      m_rd[slot]   = rd;
      m_hr[slot]   = hr;
      m_tn[slot]   = tn;
      m_to[slot]   = to;
      m_done[slot] = 0;
      order_q.push_back(slot);
      alloc_cnt++;
    end

    @(posedge clk);
    #1;
    chk("retire_valid", retire_valid_o, exp_rv);
    chk("free_valid", free_valid_o, exp_fv);
    chk("retire_rd", retire_rd_o, exp_rrd);
    chk("retire_tag", retire_tag_o, exp_rtag);
    chk("free_tag", free_tag_o, exp_ftag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    alloc_valid_i    = 1'b0;
    complete_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    order_q.delete();
    for (int i = 0; i < DEPTH; i++) m_done[i] = 0;
    alloc_cnt = 0;
    exp_rv = 0; exp_fv = 0; exp_rrd = 0; exp_rtag = 0; exp_ftag = 0;
    chk("rst_count", count_o, 0);
    chk("rst_alloc_ready", alloc_ready_o, 1);
    chk("rst_retire_valid", retire_valid_o, 0);
    chk("rst_free_valid", free_valid_o, 0);
    chk("rst_retire_rd", retire_rd_o, 0);
    chk("rst_retire_tag", retire_tag_o, 0);
    chk("rst_free_tag", free_tag_o, 0);
  endtask

  initial begin
    int prev;
    int ci;
    rst              = 1'b1;
    alloc_valid_i    = 1'b0;
    alloc_has_rd_i   = 1'b0;
    alloc_rd_i       = '0;
    alloc_tag_new_i  = '0;
    alloc_tag_old_i  = '0;
    complete_valid_i = 1'b0;
    complete_idx_i   = '0;
    alloc_cnt        = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset then idle.
    do_reset();
    idle(5);

    // Out-of-order completion, in-order retire.
    step(1, 1, 2, 33, 2, 0, 0);
    step(1, 1, 3, 34, 3, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    idle(3);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(1);
    chk("ooo_first_free_tag", free_tag_o, 2);
    chk("ooo_first_retire_rd", retire_rd_o, 2);
    idle(1);
    chk("ooo_second_free_tag", free_tag_o, 3);
    chk("ooo_second_retire_rd", retire_rd_o, 3);
    idle(2);

    // rd=0 and no-destination instructions retire without freeing.
    step(1, 1, 0, 40, 41, 0, 0);
    step(1, 0, 5, 42, 43, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 3);
    idle(4);

    // Fill to capacity, drop an alloc while full, then free one slot.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 1, i + 1, 16 + i, i + 1, 0, 0);
    chk("full_ready", alloc_ready_o, 0);
    chk("full_count", count_o, 16);
    step(1, 1, 9, 63, 62, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(1);
    chk("after_free_count", count_o, 15);
    chk("after_free_ready", alloc_ready_o, 1);
    for (int i = DEPTH - 1; i >= 1; i--) step(0, 0, 0, 0, 0, 1, i);
    idle(4);

    // Wrap-around with a steady alloc/complete stream.
    do_reset();
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, $urandom_range(1, 31), $urandom_range(0, 63), $urandom_range(0, 63), i > 0, prev);
      prev = i % DEPTH;
    end
    step(0, 0, 0, 0, 0, 1, prev);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (order_q.size() > 0 && $urandom_range(0, 3) != 0)
        ci = order_q[$urandom_range(0, order_q.size() - 1)];
      else
        ci = $urandom_range(0, DEPTH - 1);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31),
           $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 1) != 0, ci);
    end
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 1, i);
    idle(DEPTH + 2);

    // Reset mid-operation while a retire is due.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, i + 10, i + 20, i + 30, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 1, 0);
    do_reset();
    idle(2);
    chk("post_rst_alloc_idx", alloc_idx_o, 0);
    step(1, 1, 7, 50, 7, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
